// File: rtl/abs_conv_seq.sv
// abs_conv_seq -- sequential two's-complement to sign-magnitude converter.
//
// Accepts a signed (or unsigned, tc_i = 0) operand over a valid/ready
// handshake and returns its unsigned magnitude and sign bit. The negation
// ~A + 1 is done `digit` bits per cycle, LSB first. A one-bit propagate
// carries between digits.
//
// A result takes N + 1 cycles from the accept edge to out_valid_o, where
// N = width / digit. There are N digit steps and then one settle cycle
// before DONE.
//
// Parameters:
//   width        operand / magnitude width (>= 2)
//   digit        bits processed per cycle (1..width, divides width)
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   operand valid
//   in_ready_o   block can accept an operand. This output has a
//                combinational path from out_ready_i while in DONE.
//   a_i          operand
//   tc_i         1: a_i is two's complement, 0: unsigned pass-through
//   out_valid_o  result valid
//   out_ready_i  consumer accepts result
//   mag_o        unsigned magnitude
//   sign_o       operand sign (1 = negative)
//   minneg_o     operand was -2^(width-1). This port exists only when
//                ABSC_MINNEG_FLAG_EN is defined.
//
// Build option: define ABSC_MINNEG_FLAG_EN to add minneg_o and its register.

module abs_conv_seq #(
  parameter int width = 8,
  parameter int digit = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [width-1:0] a_i,
  input  logic             tc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [width-1:0] mag_o,
  output logic             sign_o
`ifdef ABSC_MINNEG_FLAG_EN
  ,
  output logic             minneg_o
`endif
);

  localparam int n  = width / digit;
  localparam int cw = $clog2(n + 1);

  if (width < 2 || digit < 1 || digit > width || (width % digit) != 0) begin : g_bad_param
    $error("abs_conv_seq: illegal width/digit combination");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [width-1:0] sr_q, sr_next;
  logic             sign_q;
  logic             carry_q, carry_d;
  logic [cw-1:0]    count_q;
  logic [digit-1:0] d, r;
  logic             accept;
  logic             last;

  assign in_ready_o  = (state_q == IDLE) | ((state_q == DONE) & out_ready_i);
  assign accept      = in_valid_i & in_ready_o;
  // When count reaches n, all digits have been converted.
  // The cycle spent at count == n is the settle cycle before DONE.
  assign last        = (count_q == cw'(n));
  assign out_valid_o = (state_q == DONE);
  assign mag_o       = sr_q;
  assign sign_o      = sign_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values and simulation matches hardware.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first; a missing branch
  // would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    if (out_ready_i) state_d = accept ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One digit step. A negative operand is negated as ~d + carry.
  // The carry keeps propagating only while the digits seen so far are zero.
  always_comb begin
    d       = sr_q[digit-1:0];
    r       = d;
    carry_d = carry_q;
    if (sign_q) begin
      r       = ~d + digit'(carry_q);
      carry_d = carry_q & (d == '0);
    end
  end

  // The converted digit enters at the MSB.
  // After n steps the register holds the whole magnitude.
  if (digit == width) begin : g_full
    assign sr_next = r;
  end else begin : g_part
    assign sr_next = {r, sr_q[width-1:digit]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q    <= '0;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
      count_q <= '0;
    end else if (accept) begin
      sr_q    <= a_i;
      sign_q  <= tc_i & a_i[width-1];
      carry_q <= 1'b1;
      count_q <= '0;
    end else if (state_q == BUSY && !last) begin
      sr_q    <= sr_next;
      carry_q <= carry_d;
      count_q <= count_q + cw'(1);
    end
  end

`ifdef ABSC_MINNEG_FLAG_EN
  logic minneg_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     minneg_q <= 1'b0;
    else if (accept) minneg_q <= tc_i && (a_i == {1'b1, {(width-1){1'b0}}});
  end

  assign minneg_o = minneg_q;
`endif

endmodule

// File: tb/tb_abs_conv_seq.sv
// Self-checking bench for abs_conv_seq.
// The directed DUT uses width 8 and digit 2.
// The sweep instances cover digit 1, 2, 4 and 8.
module tb_abs_conv_seq;

  localparam int width = 8;
  localparam int n_dir = 4;  // width / digit for the directed instance

  typedef struct {
    logic [7:0] a;
    logic       tc;
    logic [7:0] mag;
    logic       sign;
    logic       minneg;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int sweeps_done = 0;
  logic sweep_go = 1'b0;
  logic sw_rst_n = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the absolute value of the operand's numeric value.
  function automatic void ref_abs(input logic [7:0] a, input logic tc,
                                  output logic [7:0] mag, output logic sign,
                                  output logic minneg);
    int v;
    v      = tc ? int'($signed(a)) : int'(a);
    sign   = (v < 0);
    mag    = 8'((v < 0) ? -v : v);
    minneg = (v == -128);
  endfunction

  // ---------------- directed instance ----------------
  logic       rst_ni;
  logic       in_valid, in_ready, tc, out_valid, out_ready, sign, minneg;
  logic [7:0] a, mag;

  abs_conv_seq #(.width(width), .digit(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .tc_i(tc), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .mag_o(mag), .sign_o(sign)
`ifdef ABSC_MINNEG_FLAG_EN
    , .minneg_o(minneg)
`endif
  );
`ifndef ABSC_MINNEG_FLAG_EN
  assign minneg = 1'b0;
`endif

  // Offer an operand and wait, with a bound, for the accept edge.
  // The task returns 1 ns after that edge.
  // The inputs are then scrambled to show they are sampled only at accept.
  task automatic offer(input logic [7:0] av, input logic tcv);
    int k;
    k = 0;
    @(negedge clk);
    in_valid = 1'b1; a = av; tc = tcv;
    #1;
    while (!in_ready && k < 50) begin @(negedge clk); #1; k++; end
    check("accept_timeout", 32'(k < 50), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); tc = 1'($urandom);
  endtask

  // Count the edges after the accept edge until out_valid is seen.
  // The task returns at that negedge.
  task automatic wait_result(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    offer(v.a, v.tc);
    wait_result(lat);
    check({tag, "_latency"}, lat, n_dir + 1);
    check({tag, "_mag"}, mag, v.mag);
    check({tag, "_sign"}, sign, v.sign);
`ifdef ABSC_MINNEG_FLAG_EN
    check({tag, "_minneg"}, minneg, v.minneg);
`endif
    consume();
  endtask

  // ---------------- randomized sweep instances ----------------
  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int dg = 1 << g;
    localparam int ng = width / dg;
    logic       s_in_valid, s_in_ready, s_tc, s_out_valid, s_out_ready, s_sign, s_minneg;
    logic [7:0] s_a, s_mag;

    abs_conv_seq #(.width(width), .digit(dg)) u_dut (
      .clk_i(clk), .rst_ni(sw_rst_n), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
      .a_i(s_a), .tc_i(s_tc), .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
      .mag_o(s_mag), .sign_o(s_sign)
`ifdef ABSC_MINNEG_FLAG_EN
      , .minneg_o(s_minneg)
`endif
    );
`ifndef ABSC_MINNEG_FLAG_EN
    assign s_minneg = 1'b0;
`endif

    initial begin
      logic [8:0] vec [512];
      logic [8:0] t;
      logic [7:0] av, em;
      logic       tcv, es, emn;
      int         j, k, lat, stall;
      s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_tc = 1'b0;
      for (int i = 0; i < 512; i++) vec[i] = 9'(i);
      for (int i = 511; i > 0; i--) begin
        j = $urandom_range(i, 0);
        t = vec[i]; vec[i] = vec[j]; vec[j] = t;
      end
      wait (sweep_go);
      for (int i = 0; i < 512; i++) begin
        av = vec[i][7:0]; tcv = vec[i][8];
        ref_abs(av, tcv, em, es, emn);
        @(negedge clk);
        s_in_valid = 1'b1; s_a = av; s_tc = tcv;
        #1;
        k = 0;
        while (!s_in_ready && k < 50) begin @(negedge clk); #1; k++; end
        if (k >= 50) check($sformatf("d%0d_accept_timeout", dg), 0, 1);
        @(posedge clk); #1;
        s_in_valid = 1'b0; s_a = 8'($urandom); s_tc = 1'($urandom);
        lat = 0;
        @(negedge clk);
        while (!s_out_valid && lat < 50) begin @(negedge clk); lat++; end
        check($sformatf("d%0d_lat a=%02h tc=%0d", dg, av, tcv), lat, ng + 1);
        check($sformatf("d%0d_mag a=%02h tc=%0d", dg, av, tcv), s_mag, em);
        check($sformatf("d%0d_sign a=%02h tc=%0d", dg, av, tcv), s_sign, es);
`ifdef ABSC_MINNEG_FLAG_EN
        check($sformatf("d%0d_minneg a=%02h tc=%0d", dg, av, tcv), s_minneg, emn);
`endif
        stall = $urandom_range(2, 0);
        repeat (stall) @(negedge clk);
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
      end
      sweeps_done++;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t tbl [6];
    int   lat, k;

    tbl[0] = '{a: 8'hFB, tc: 1'b1, mag: 8'h05, sign: 1'b1, minneg: 1'b0};
    tbl[1] = '{a: 8'h80, tc: 1'b1, mag: 8'h80, sign: 1'b1, minneg: 1'b1};
    tbl[2] = '{a: 8'h81, tc: 1'b1, mag: 8'h7F, sign: 1'b1, minneg: 1'b0};
    tbl[3] = '{a: 8'h00, tc: 1'b1, mag: 8'h00, sign: 1'b0, minneg: 1'b0};
    tbl[4] = '{a: 8'hFB, tc: 1'b0, mag: 8'hFB, sign: 1'b0, minneg: 1'b0};
    tbl[5] = '{a: 8'h80, tc: 1'b0, mag: 8'h80, sign: 1'b0, minneg: 1'b0};

    rst_ni = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; tc = 1'b0;
    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_mag", mag, 0);
    check("reset_sign", sign, 0);
    check("reset_minneg", minneg, 0);
    @(negedge clk);
    rst_ni = 1'b1; sw_rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Backpressure: the result is held for 10 cycles while another
    // operand waits. That operand is accepted in the cycle out_ready rises.
    offer(8'h9C, 1'b1);
    wait_result(lat);
    check("bp_latency", lat, n_dir + 1);
    in_valid = 1'b1; a = 8'h33; tc = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check($sformatf("bp_hold_valid%0d", i), out_valid, 1);
      check($sformatf("bp_hold_mag%0d", i), mag, 8'h64);
      check($sformatf("bp_hold_sign%0d", i), sign, 1);
      check($sformatf("bp_hold_ready%0d", i), in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_ready_passthru", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0; a = 8'hFF; tc = 1'b1;
    wait_result(lat);
    check("bp_next_latency", lat, n_dir + 1);
    check("bp_next_mag", mag, 8'h33);
    check("bp_next_sign", sign, 0);
    consume();

    // Reset in the second BUSY cycle discards the operation.
    offer(8'hFB, 1'b1);
    @(posedge clk); #2;
    rst_ni = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_mag", mag, 0);
    check("midrst_sign", sign, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk); @(negedge clk);
    rst_ni = 1'b1;
    k = 0;
    repeat (8) begin @(negedge clk); if (out_valid) k++; end
    check("midrst_no_output", k, 0);
    run_vec('{a: 8'h7F, tc: 1'b1, mag: 8'h7F, sign: 1'b0, minneg: 1'b0}, "post_rst");

    // Randomized sweep on all digit sizes.
    sweep_go = 1'b1;
    k = 0;
    while (sweeps_done < 4 && k < 30000) begin @(negedge clk); k++; end
    check("sweep_timeout", sweeps_done, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/abs_conv_seq.md
# abs_conv_seq

Sequential two's-complement to sign-magnitude converter: the inverse direction of the conditional complementer. It accepts a signed operand over a valid/ready handshake and returns its unsigned magnitude and sign bit. Negation (~A + 1) is computed iteratively, `digit` bits per cycle, LSB first, with a one-bit propagate carried between cycles. It sits in front of sign-magnitude datapaths (dividers, normalisers) where area matters more than latency.

## Interface
- `width`, 8, operand and magnitude width; must be ≥ 2.
- `digit`, 2, bits processed per cycle; 1 ≤ digit ≤ width, width % digit == 0 (elaboration error otherwise).
- `clk_i`  input  1  clock, all state on rising edge.
- `rst_ni`  input  1  reset, asynchronous, active-low.
- `in_valid_i`  input  1  operand valid.
- `in_ready_o`  output  1  block can accept an operand.
- `a_i`  input  width  operand.
- `tc_i`  input  1  1: a_i is two's complement; 0: a_i is unsigned, pass through.
- `out_valid_o`  output  1  result valid.
- `out_ready_i`  input  1  consumer accepts result.
- `mag_o`  output  width  unsigned magnitude.
- `sign_o`  output  1  sign of operand (1 = negative).
- `minneg_o`  output  1  only with ABSC_MINNEG_FLAG_EN; operand was -2^(width-1).

## Operation
- N = width/digit. States: IDLE, BUSY, DONE.
- IDLE: in_ready_o = 1. On in_valid_i && in_ready_o: sign = tc_i & a_i[width-1]; load shift register with a_i; carry = 1; count = 0; go BUSY.
- BUSY: per cycle take low `digit` bits d. If sign: r = ~d + carry (digit bits), carry_next = carry & (d == 0). Else r = d, carry unchanged. Shift register right by digit, r inserted at MSB. count++. After N cycles go DONE.
- DONE: out_valid_o = 1; mag_o = shift register, sign_o registered sign. Held stable until out_ready_i. On handshake go IDLE, or directly BUSY if a new operand is accepted the same cycle.
- in_ready_o = (state == IDLE) | (state == DONE & out_ready_i). Combinational out_ready_i → in_ready_o path is intentional.
- Magnitude is unsigned `width` bits. -2^(width-1) yields mag 2^(width-1), sign 1, no overflow.
- Zero: mag 0, sign 0 regardless of tc_i.
- tc_i = 0: mag_o = a_i, sign_o = 0, same latency.
- a_i and tc_i are sampled only at the accept edge; later changes are ignored.

## Timing
- Reset (async assert, any state): state IDLE, in_ready_o = 1 (combinational from IDLE), out_valid_o = 0, mag_o = 0, sign_o = 0, minneg_o = 0, count = 0. An in-flight operation is discarded with no output.
- Latency: accept at edge T, out_valid_o rises at edge T+N+1 (N BUSY cycles plus one DONE register stage transition).
- Throughput: one result per N+1 cycles with out_ready_i held high.
- in_valid_i high while in_ready_o low: no accept, no state change. The producer holds its data.
- out_valid_o never drops without a handshake; mag_o/sign_o stable while out_valid_o && !out_ready_i.
- digit == width: N = 1, full-width negation in one cycle.

## Configuration
- `ABSC_MINNEG_FLAG_EN` defined: adds the `minneg_o` port and one register. It is set at the accept edge when tc_i && a_i == {1'b1, {width-1{1'b0}}}, valid with out_valid_o, cleared on reset and on the next accept.
- Undefined: no `minneg_o` port and no register. All other behaviour is identical.

## Test plan
- width=8, digit=2: accept a_i=0xFB, tc_i=1 → after 4 BUSY cycles out_valid_o=1, mag_o=0x05, sign_o=1.
- a_i=0x80, tc_i=1 → mag_o=0x80, sign_o=1; with ABSC_MINNEG_FLAG_EN, minneg_o=1. Then a_i=0x81 → mag 0x7F, minneg_o=0.
- a_i=0x00 with tc_i=1 → mag 0x00, sign 0. a_i=0xFB with tc_i=0 → mag 0xFB, sign 0.
- Backpressure: out_ready_i=0 for 10 cycles after the result → mag_o/sign_o stable, in_ready_o=0. A new operand offered in the same cycle out_ready_i rises is accepted; next result arrives 5 cycles later.
- Reset asserted during the 2nd BUSY cycle of 0xFB → outputs zero immediately, no out_valid_o. After release, a_i=0x7F → mag 0x7F, sign 0.
- Randomised sweep of all 256 operands × tc_i, for digit ∈ {1,2,4,8}, against |a| reference model and latency N+1.
